// File: rtl/symbol_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module : symbol_packer_pkg
// Brief  : Shared widths, the pad-width helper and the FSM state type for the
//          5-bit to 8-bit symbol packer.
// Rev    : 1.0  initial release
// ============================================================================
package symbol_packer_pkg;

    localparam int SYM_W_DEF          = 5;
    localparam int OUT_W_DEF          = 8;
    localparam int SYMS_PER_FRAME_DEF = 6;

    // Ones appended after the last symbol so that a frame ends on a byte boundary.
    function automatic int calc_pad_w(input int sym_w, input int out_w, input int syms);
        return out_w - ((syms * sym_w) % out_w);
    endfunction

    localparam int PAD_W_DEF = calc_pad_w(SYM_W_DEF, OUT_W_DEF, SYMS_PER_FRAME_DEF);

    localparam logic [31:0] PAD_VALUE = '1;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_PAD   = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/symbol_packer_if.sv
`default_nettype none
// ============================================================================
// Module : symbol_packer_if
// Brief  : Symbol-in / byte-out handshake bundle for the symbol packer.
// Rev    : 1.0  initial release
// ============================================================================
interface symbol_packer_if
    import symbol_packer_pkg::*;
#(
    parameter int SYM_W = SYM_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);

    logic [SYM_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    // Environment side: symbol source and byte sink.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last
    );

endinterface
`default_nettype wire

// File: rtl/symbol_packer_shift_buf.sv
`default_nettype none
// ============================================================================
// Module : pack_shift_buf
// Brief  : MSB-aligned 2*OUT_W bit buffer with occupancy count, write at the
//          fill offset and a byte pop that shifts left.
// Rev    : 1.0  initial release
// ============================================================================
module pack_shift_buf
    import symbol_packer_pkg::*;
#(
    parameter int SYM_W = SYM_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int PAD_W = PAD_W_DEF
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             pop,
    input  wire logic             wr_en,
    input  wire logic             wr_pad,
    input  wire logic [SYM_W-1:0] wr_data,
    output logic      [OUT_W-1:0] head,
    output logic                  byte_valid,
    output logic                  sym_room,
    output logic                  pad_room
);

    localparam int BUF_W = 2 * OUT_W;
    localparam int CNT_W = $clog2(BUF_W + 1);

    localparam logic [CNT_W-1:0] C_OUT_W    = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] C_SYM_W    = CNT_W'(SYM_W);
    localparam logic [CNT_W-1:0] C_PAD_W    = CNT_W'(PAD_W);
    localparam logic [CNT_W-1:0] C_SYM_ROOM = CNT_W'(BUF_W - SYM_W);
    localparam logic [CNT_W-1:0] C_PAD_ROOM = CNT_W'(BUF_W - PAD_W);
    localparam logic [BUF_W-1:0] C_PAD_VEC  = {PAD_VALUE[PAD_W-1:0], {(BUF_W-PAD_W){1'b0}}};

    logic [BUF_W-1:0] shreg_q;
    logic [BUF_W-1:0] shreg_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [BUF_W-1:0] w_shreg_popped;
    logic [CNT_W-1:0] w_cnt_popped;
    logic [BUF_W-1:0] w_wr_vec;

    // Bits below the fill level are always zero, so a write is a plain OR.
    always_comb begin
        w_shreg_popped = shreg_q;
        w_cnt_popped   = cnt_q;
        if (pop) begin
            w_shreg_popped = shreg_q << OUT_W;
            w_cnt_popped   = cnt_q - C_OUT_W;
        end

        w_wr_vec = wr_pad ? C_PAD_VEC : {wr_data, {(BUF_W-SYM_W){1'b0}}};

        shreg_d = w_shreg_popped;
        cnt_d   = w_cnt_popped;
        if (wr_en) begin
            shreg_d = w_shreg_popped | (w_wr_vec >> w_cnt_popped);
            cnt_d   = w_cnt_popped + (wr_pad ? C_PAD_W : C_SYM_W);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign head       = shreg_q[BUF_W-1 -: OUT_W];
    assign byte_valid = (cnt_q >= C_OUT_W);
    assign sym_room   = (cnt_q <= C_SYM_ROOM);
    assign pad_room   = (w_cnt_popped <= C_PAD_ROOM);

endmodule
`default_nettype wire

// File: rtl/symbol_packer.sv
`default_nettype none
// ============================================================================
// Module : symbol_packer
// Brief  : Packs SYM_W-bit symbols MSB-first into OUT_W-bit bytes, closing
//          each frame with ones. SYMBOL_PACKER_STATS_EN adds frame_cnt.
// Rev    : 1.0  initial release
// ============================================================================
module symbol_packer
    import symbol_packer_pkg::*;
#(
    parameter int SYM_W          = SYM_W_DEF,
    parameter int OUT_W          = OUT_W_DEF,
    parameter int SYMS_PER_FRAME = SYMS_PER_FRAME_DEF
) (
    input  wire logic         clk,
    input  wire logic         reset,
    symbol_packer_if.slave    bus
`ifdef SYMBOL_PACKER_STATS_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int PAD_W = calc_pad_w(SYM_W, OUT_W, SYMS_PER_FRAME);
    localparam int IDX_W = (SYMS_PER_FRAME > 1) ? $clog2(SYMS_PER_FRAME) : 1;
    localparam logic [IDX_W-1:0] C_LAST_SYM = IDX_W'(SYMS_PER_FRAME - 1);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] sym_idx_q;
    logic [IDX_W-1:0] sym_idx_d;
    logic [1:0]       byte_idx_q;
    logic [1:0]       byte_idx_d;

    logic             w_in_ready;
    logic             w_wr_en;
    logic             w_wr_pad;
    logic             w_pop;
    logic             w_last;
    logic [OUT_W-1:0] w_head;
    logic             w_byte_valid;
    logic             w_sym_room;
    logic             w_pad_room;

    pack_shift_buf #(
        .SYM_W (SYM_W),
        .OUT_W (OUT_W),
        .PAD_W (PAD_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .pop        (w_pop),
        .wr_en      (w_wr_en),
        .wr_pad     (w_wr_pad),
        .wr_data    (bus.in_data),
        .head       (w_head),
        .byte_valid (w_byte_valid),
        .sym_room   (w_sym_room),
        .pad_room   (w_pad_room)
    );

    assign w_pop  = w_byte_valid && bus.out_ready;
    assign w_last = (byte_idx_q == 2'd3);

    always_comb begin
        state_d    = state_q;
        sym_idx_d  = sym_idx_q;
        byte_idx_d = byte_idx_q;
        w_in_ready = 1'b0;
        w_wr_en    = 1'b0;
        w_wr_pad   = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                w_in_ready = w_sym_room;
                if (bus.in_valid && w_sym_room) begin
                    w_wr_en = 1'b1;
                    if (sym_idx_q == C_LAST_SYM) begin
                        sym_idx_d = '0;
                        state_d   = ST_PAD;
                    end else begin
                        sym_idx_d = sym_idx_q + 1'b1;
                    end
                end
            end
            ST_PAD: begin
                // Room is judged after this cycle's pop, so a draining sink never costs a cycle.
                if (w_pad_room) begin
                    w_wr_en  = 1'b1;
                    w_wr_pad = 1'b1;
                    state_d  = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase

        if (w_pop) begin
            byte_idx_d = byte_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ACCUM;
            sym_idx_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            sym_idx_q  <= sym_idx_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = w_head;
    assign bus.out_valid = w_byte_valid;
    assign bus.out_last  = w_last;

`ifdef SYMBOL_PACKER_STATS_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (w_pop && w_last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_symbol_packer.sv
`default_nettype none
// ============================================================================
// Module : tb_symbol_packer
// Brief  : Self-checking bench for symbol_packer with a bit-queue reference.
// Rev    : 1.0  initial release
// ============================================================================
module tb_symbol_packer;
    import symbol_packer_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    symbol_packer_if bus ();

`ifdef SYMBOL_PACKER_STATS_EN
    logic [15:0] frame_cnt;
`endif

    symbol_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SYMBOL_PACKER_STATS_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [4:0] sym_q[$];
    logic [7:0] got_d[$];
    bit         got_l[$];

    // Feeds sym_q with out_ready high and records every byte popped.
    task automatic stream(input int n_bytes);
        int cyc;
        cyc = 0;
        got_d.delete();
        got_l.delete();
        while (got_d.size() < n_bytes && cyc < 500) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (sym_q.size() > 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = sym_q[0];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = '0;
            end
            if (bus.in_valid && bus.in_ready) void'(sym_q.pop_front());
            if (bus.out_valid) begin
                got_d.push_back(bus.out_data);
                got_l.push_back(bus.out_last);
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        vectors++;
        if (bus.out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        vectors++;
        if (bus.out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
        vectors++;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic;
        logic [7:0] exp_b [4];
        exp_b = '{8'h08, 8'h86, 8'h42, 8'h9B};
        sym_q = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        stream(4);
        vectors++;
        if (got_d.size() != 4) begin miscompares++; $display("FAIL basic_count: got %0d want 4", got_d.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_d.size()) begin
                vectors++;
                if (got_d[i] !== exp_b[i] || got_l[i] !== (i == 3)) begin
                    miscompares++;
                    $display("FAIL basic_byte%0d: got %h last %b want %h last %b", i, got_d[i], got_l[i], exp_b[i], (i == 3));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [8];
        exp_b = '{8'h00, 8'h00, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        sym_q.delete();
        for (int i = 0; i < 6; i++) sym_q.push_back(5'h00);
        for (int i = 0; i < 6; i++) sym_q.push_back(5'h1F);
        stream(8);
        vectors++;
        if (got_d.size() != 8) begin miscompares++; $display("FAIL b2b_count: got %0d want 8", got_d.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < got_d.size()) begin
                vectors++;
                if (got_d[i] !== exp_b[i] || got_l[i] !== (i % 4 == 3)) begin
                    miscompares++;
                    $display("FAIL b2b_byte%0d: got %h last %b want %h last %b", i, got_d[i], got_l[i], exp_b[i], (i % 4 == 3));
                end
            end
        end
    endtask

    task automatic test_stall;
        logic [7:0] exp_b [4];
        exp_b = '{8'h08, 8'h86, 8'h42, 8'h9B};
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 5'd1;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_early_valid: got %b want 0", bus.out_valid); end
        bus.in_data = 5'd2;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h08) begin
            miscompares++; $display("FAIL stall_first_byte: got valid %b data %h want 1 08", bus.out_valid, bus.out_data);
        end
        bus.in_data = 5'd3;
        @(negedge clk);
        bus.in_data = 5'd4;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h08) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got ready %b valid %b data %h want 0 1 08", i, bus.in_ready, bus.out_valid, bus.out_data);
            end
            @(negedge clk);
        end
        sym_q = '{5'd4, 5'd5, 5'd6};
        stream(4);
        vectors++;
        if (got_d.size() != 4) begin miscompares++; $display("FAIL stall_count: got %0d want 4", got_d.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_d.size()) begin
                vectors++;
                if (got_d[i] !== exp_b[i] || got_l[i] !== (i == 3)) begin
                    miscompares++;
                    $display("FAIL stall_byte%0d: got %h last %b want %h last %b", i, got_d[i], got_l[i], exp_b[i], (i == 3));
                end
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] exp_b [4];
        exp_b = '{8'h08, 8'h86, 8'h42, 8'h9B};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 5'(i + 1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h08) begin
            miscompares++; $display("FAIL mid_pre_reset: got valid %b data %h want 1 08", bus.out_valid, bus.out_data);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_post_reset: got valid %b ready %b last %b want 0 1 0", bus.out_valid, bus.in_ready, bus.out_last);
        end
        sym_q = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        stream(4);
        vectors++;
        if (got_d.size() != 4) begin miscompares++; $display("FAIL mid_count: got %0d want 4", got_d.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_d.size()) begin
                vectors++;
                if (got_d[i] !== exp_b[i] || got_l[i] !== (i == 3)) begin
                    miscompares++;
                    $display("FAIL mid_byte%0d: got %h last %b want %h last %b", i, got_d[i], got_l[i], exp_b[i], (i == 3));
                end
            end
        end
    endtask

    // Reference: every frame is its symbols' bits in order followed by two ones, cut into bytes.
    task automatic test_random;
        bit         bitq[$];
        int         total_syms;
        int         total_bytes;
        int         syms_sent;
        int         bytes_got;
        int         cyc;
        bit         prev_stall;
        logic [7:0] prev_d;
        logic [7:0] e_byte;
        total_syms  = 1000 * 6;
        total_bytes = 1000 * 4;
        syms_sent   = 0;
        bytes_got   = 0;
        cyc         = 0;
        prev_stall  = 1'b0;
        prev_d      = '0;
        while ((syms_sent < total_syms || bytes_got < total_bytes) && cyc < 60000) begin
            @(negedge clk);
            if (prev_stall) begin
                vectors++;
                if (bus.out_data !== prev_d) begin
                    miscompares++; $display("FAIL rand_hold cyc %0d: got %h want %h", cyc, bus.out_data, prev_d);
                end
            end
            bus.in_valid  = (syms_sent < total_syms) && ($urandom_range(0, 1) == 1);
            bus.in_data   = 5'($urandom_range(0, 31));
            bus.out_ready = ($urandom_range(0, 1) == 1);
            if (bus.out_valid && bus.out_ready) begin
                e_byte = '0;
                vectors++;
                if (bitq.size() < 8) begin
                    miscompares++; $display("FAIL rand_extra_byte %0d: got %h want none", bytes_got, bus.out_data);
                end else begin
                    for (int b = 0; b < 8; b++) e_byte = {e_byte[6:0], bitq.pop_front()};
                    if (bus.out_data !== e_byte || bus.out_last !== (bytes_got % 4 == 3)) begin
                        miscompares++;
                        $display("FAIL rand_byte %0d: got %h last %b want %h last %b",
                                 bytes_got, bus.out_data, bus.out_last, e_byte, (bytes_got % 4 == 3));
                    end
                end
                bytes_got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int b = 4; b >= 0; b--) bitq.push_back(bus.in_data[b]);
                syms_sent++;
                if (syms_sent % 6 == 0) begin
                    bitq.push_back(1'b1);
                    bitq.push_back(1'b1);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d     = bus.out_data;
            cyc++;
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        vectors++;
        if (bytes_got != total_bytes || bitq.size() != 0) begin
            miscompares++;
            $display("FAIL rand_totals: got %0d bytes %0d bits left want %0d bytes 0 bits", bytes_got, bitq.size(), total_bytes);
        end
    endtask

`ifdef SYMBOL_PACKER_STATS_EN
    task automatic test_stats;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sym_q = '{5'd7, 5'd8, 5'd9};
        stream(1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL stats_partial: got %0d want 0", frame_cnt); end
        sym_q.delete();
        for (int i = 0; i < 30; i++) sym_q.push_back(5'($urandom_range(0, 31)));
        stream(20);
        @(negedge clk);
        vectors++;
        if (frame_cnt !== 16'd5) begin miscompares++; $display("FAIL stats_frames: got %0d want 5", frame_cnt); end
    endtask
`endif

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_midframe();
        test_random();
`ifdef SYMBOL_PACKER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
